// File: rtl/mul_issue_ctrl.sv
// Operand/result sequencer wrapped around the radix-8 Booth multiplier datapath.
// Latency: accept -> 1 LAUNCH cycle -> BUSY until mul_done -> result valid next cycle; one op in flight, no queuing.
module mul_issue_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int PROD_W  = 67,
  parameter int RES_W   = 64
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_x,
  input  logic [31:0]       in_y,
  output logic [31:0]       mul_x,
  output logic [31:0]       mul_y,
  output logic              mul_active,
  input  logic              mul_done,
  input  logic [PROD_W-1:0] mul_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_res,
  output logic              out_ovf,
  output logic              out_err,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_BUSY   = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] wdog;
  logic [PROD_W-RES_W:0] prod_hi;
  logic          prod_ovf;

  // The product fits only when the bits above the result are a pure sign extension.
  assign prod_hi  = mul_product[PROD_W-1:RES_W-1];
  assign prod_ovf = !((&prod_hi) || (~|prod_hi));

  assign in_ready   = (state == ST_IDLE);
  assign mul_active = (state == ST_LAUNCH) || (state == ST_BUSY);
  assign out_valid  = (state == ST_HOLD);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= ST_IDLE;
      wdog    <= '0;
      mul_x   <= '0;
      mul_y   <= '0;
      out_res <= '0;
      out_ovf <= 1'b0;
      out_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mul_x <= in_x;
            mul_y <= in_y;
            state <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          wdog  <= '0;
          state <= ST_BUSY;
        end
        ST_BUSY: begin
          wdog <= wdog + CW'(1);
          // A done strobe on the final watchdog cycle still counts as a completion.
          if (mul_done) begin
            out_res <= mul_product[RES_W-1:0];
            out_ovf <= prod_ovf;
            out_err <= 1'b0;
            state   <= ST_HOLD;
          end else if (wdog == WDOG_LAST) begin
            out_res <= '0;
            out_ovf <= 1'b0;
            out_err <= 1'b1;
            state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
